dmem_bus_ctrl: RTL and testbench

//  Data-memory bus controller directly downstream of the datapath M stage.

---
 rtl/dmem_bus_ctrl.sv | 145 ++++++++++++++
 tb/tb_dmem_bus_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_bus_ctrl
//  Description : Data-memory bus controller behind the M stage. Converts an
//                M-stage load/store into a single req/ack bus transaction,
//                stalls M until a result is available, holds that result
//                until the pipeline advances, and aborts dead slaves on a
//                timeout with a sticky error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_bus_ctrl #(
   parameter int          ADDR_W  = 18,
   parameter int          TIMEOUT = 64,
   parameter logic [31:0] ERR_VAL = 32'h0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_rd_M,
   input  logic              mem_wr_M,
   input  logic [31:0]       addr_M,
   input  logic [31:0]       wdata_M,
   input  logic [3:0]        byte_en_M,
   input  logic              advance_M,
   input  logic              flush_M,
   input  logic              err_clr,
   output logic [31:0]       read_data_M,
   output logic              data_mem_ack,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-3:0] bus_addr,
   output logic [31:0]       bus_wdata,
   output logic [3:0]        bus_be,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rdata,
   output logic              bus_err,
   output logic [31:0]       err_addr
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_count;
   logic              r_discard;   // M-stage owner of the in-flight access was squashed
   logic [31:0]       r_addr;      // full byte address of the in-flight access

   logic w_req;
   logic w_drop;
   logic w_expire;

   // Request qualification, result drop decision and timeout detect
   always_comb begin
      w_req        = (mem_rd_M | mem_wr_M) & ~flush_M;
      w_drop       = r_discard | flush_M;
      w_expire     = (r_count == c_cnt_last);
      data_mem_ack = ~w_req | (r_state == S_DONE);
   end

   // Transaction sequencer: issue, wait for ack or timeout, hold result
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_count     <= '0;
         r_discard   <= 1'b0;
         r_addr      <= '0;
         bus_req     <= 1'b0;
         bus_we      <= 1'b0;
         bus_addr    <= '0;
         bus_wdata   <= '0;
         bus_be      <= '0;
         read_data_M <= '0;
         bus_err     <= 1'b0;
         err_addr    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  bus_req   <= 1'b1;
                  bus_we    <= mem_wr_M;
                  bus_addr  <= addr_M[ADDR_W-1:2];
                  bus_wdata <= wdata_M;
                  bus_be    <= mem_wr_M ? byte_en_M : 4'hF;
                  r_addr    <= addr_M;
                  r_count   <= '0;
                  r_discard <= 1'b0;
                  r_state   <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_count <= r_count + 1'b1;
               // A squash never aborts the bus cycle; it only marks the result as unwanted
               if (flush_M) begin
                  r_discard <= 1'b1;
               end
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  if (w_drop) begin
                     r_state <= S_IDLE;
                  end else begin
                     if (!bus_we) begin
                        read_data_M <= bus_rdata;
                     end
                     r_state <= S_DONE;
                  end
               end else if (w_expire) begin
                  bus_req <= 1'b0;
                  bus_err <= 1'b1;
                  if (!bus_err) begin
                     err_addr <= r_addr;
                  end
                  if (w_drop) begin
                     r_state <= S_IDLE;
                  end else begin
                     if (!bus_we) begin
                        read_data_M <= ERR_VAL;
                     end
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               // Return to IDLE first so the held request is not sampled twice
               if (advance_M || flush_M) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
         // Clear wins over a same-cycle timeout set
         if (err_clr) begin
            bus_err <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_bus_ctrl
//  Description : Self-checking bench for dmem_bus_ctrl. Acts as both the
//                pipeline and the bus slave; expectations come from a
//                transaction-level model of the controller's rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_bus_ctrl;

   logic        clk;
   logic        reset;
   logic        mem_rd_M;
   logic        mem_wr_M;
   logic [31:0] addr_M;
   logic [31:0] wdata_M;
   logic [3:0]  byte_en_M;
   logic        advance_M;
   logic        flush_M;
   logic        err_clr;
   logic [31:0] read_data_M;
   logic        data_mem_ack;
   logic        bus_req;
   logic        bus_we;
   logic [15:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        bus_err;
   logic [31:0] err_addr;

   int checks   = 0;
   int failures = 0;

   // Reference model state: the load result the pipeline should see
   logic [31:0] m_rdata;

   dmem_bus_ctrl #(
      .ADDR_W (18),
      .TIMEOUT(64),
      .ERR_VAL(32'h0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_rd_M    (mem_rd_M),
      .mem_wr_M    (mem_wr_M),
      .addr_M      (addr_M),
      .wdata_M     (wdata_M),
      .byte_en_M   (byte_en_M),
      .advance_M   (advance_M),
      .flush_M     (flush_M),
      .err_clr     (err_clr),
      .read_data_M (read_data_M),
      .data_mem_ack(data_mem_ack),
      .bus_req     (bus_req),
      .bus_we      (bus_we),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_be      (bus_be),
      .bus_ack     (bus_ack),
      .bus_rdata   (bus_rdata),
      .bus_err     (bus_err),
      .err_addr    (err_addr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete access: issue, slave answers after 'waits' wait states,
   // pipeline holds off advancing for 'hold' cycles once the result is ready.
   task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int waits, input logic [31:0] rdata,
                         input int hold);
      int stalls;
      int reqs;
      logic [3:0] exp_be;
      exp_be    = wr ? be : 4'hF;
      mem_rd_M  = !wr;
      mem_wr_M  = wr;
      addr_M    = addr;
      wdata_M   = wdata;
      byte_en_M = be;
      advance_M = 1'b0;
      #1;
      stalls = data_mem_ack ? 0 : 1;
      reqs   = 0;
      chk("req_before_issue", {31'd0, bus_req}, 32'd0);
      step();
      for (int c = 0; c <= waits; c++) begin
         if (!data_mem_ack) stalls++;
         if (bus_req) reqs++;
         chk("bus_addr", {16'd0, bus_addr}, {16'd0, addr[17:2]});
         chk("bus_we", {31'd0, bus_we}, {31'd0, wr});
         chk("bus_be", {28'd0, bus_be}, {28'd0, exp_be});
         chk("bus_wdata", bus_wdata, wdata);
         if (c == waits) begin
            bus_ack   = 1'b1;
            bus_rdata = rdata;
         end
         step();
         bus_ack   = 1'b0;
         bus_rdata = $urandom;
      end
      chk("stall_cycles", 32'(stalls), 32'(waits + 2));
      chk("req_cycles", 32'(reqs), 32'(waits + 1));
      if (!wr) m_rdata = rdata;
      for (int h = 0; h <= hold; h++) begin
         chk("done_ack", {31'd0, data_mem_ack}, 32'd1);
         chk("done_req_low", {31'd0, bus_req}, 32'd0);
         chk("read_data", read_data_M, m_rdata);
         if (h < hold) step();
      end
      advance_M = 1'b1;
      step();
      advance_M = 1'b0;
      mem_rd_M  = 1'b0;
      mem_wr_M  = 1'b0;
      #1;
      chk("idle_req_low", {31'd0, bus_req}, 32'd0);
      chk("idle_ack", {31'd0, data_mem_ack}, 32'd1);
   endtask

   // Load to a silent slave; expects a 64-cycle request then an error result
   task automatic timeout_load(input logic [31:0] addr, input logic [31:0] exp_err_addr,
                               input logic exp_err);
      int n;
      mem_rd_M = 1'b1;
      addr_M   = addr;
      step();
      n = 0;
      while (bus_req && n < 200) begin
         n++;
         step();
      end
      chk("timeout_req_cycles", 32'(n), 32'd64);
      m_rdata = 32'h0;
      chk("timeout_rdata", read_data_M, m_rdata);
      chk("timeout_ack", {31'd0, data_mem_ack}, 32'd1);
      chk("timeout_bus_err", {31'd0, bus_err}, {31'd0, exp_err});
      chk("timeout_err_addr", err_addr, exp_err_addr);
      advance_M = 1'b1;
      step();
      advance_M = 1'b0;
      mem_rd_M  = 1'b0;
   endtask

   initial begin
      reset     = 1'b0;
      mem_rd_M  = 1'b0;
      mem_wr_M  = 1'b0;
      addr_M    = '0;
      wdata_M   = '0;
      byte_en_M = '0;
      advance_M = 1'b0;
      flush_M   = 1'b0;
      err_clr   = 1'b0;
      bus_ack   = 1'b0;
      bus_rdata = '0;
      m_rdata   = '0;

      // Reset state
      #22;
      chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst_read_data", read_data_M, 32'd0);
      chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
      chk("rst_err_addr", err_addr, 32'd0);
      chk("rst_ack", {31'd0, data_mem_ack}, 32'd1);
      reset = 1'b1;
      step();

      // Zero-wait load: bus_addr 0x41, two stall cycles
      access(1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 0);
      // Store with three wait states
      access(1'b1, 32'h0000_0230, 32'h00AB_00AB, 4'b0010, 3, 32'hDEAD_BEEF, 0);
      // Load whose result is held five cycles before advancing
      access(1'b0, 32'h0000_0F08, 32'h0, 4'h0, 1, 32'h1234_5678, 5);

      // Timeouts: first latches err_addr, second leaves it alone
      timeout_load(32'h0000_2000, 32'h0000_2000, 1'b1);
      timeout_load(32'h0000_3000, 32'h0000_2000, 1'b1);
      // Late ack in IDLE is ignored
      bus_ack   = 1'b1;
      bus_rdata = 32'h5555_AAAA;
      step();
      bus_ack = 1'b0;
      chk("late_ack_req", {31'd0, bus_req}, 32'd0);
      chk("late_ack_rdata", read_data_M, m_rdata);
      err_clr = 1'b1;
      step();
      chk("err_clr", {31'd0, bus_err}, 32'd0);
      // Clear held through a timeout wins over the set; err_addr relatches
      timeout_load(32'h0000_4000, 32'h0000_4000, 1'b0);
      err_clr = 1'b0;

      // Flush during BUSY followed by a new load
      mem_rd_M = 1'b1;
      addr_M   = 32'h0000_0500;
      step();
      flush_M = 1'b1;
      step();
      flush_M = 1'b0;
      addr_M  = 32'h0000_0600;
      #1;
      chk("flush_ack_low", {31'd0, data_mem_ack}, 32'd0);
      chk("flush_old_addr", {16'd0, bus_addr}, 32'h0000_0140);
      step();
      bus_ack   = 1'b1;
      bus_rdata = 32'hBAD0_BAD0;
      step();
      bus_ack = 1'b0;
      chk("discard_req_low", {31'd0, bus_req}, 32'd0);
      chk("discard_ack_low", {31'd0, data_mem_ack}, 32'd0);
      chk("discard_rdata", read_data_M, m_rdata);
      step();
      chk("second_req", {31'd0, bus_req}, 32'd1);
      chk("second_addr", {16'd0, bus_addr}, 32'h0000_0180);
      chk("second_ack_low", {31'd0, data_mem_ack}, 32'd0);
      bus_ack   = 1'b1;
      bus_rdata = 32'h0BAD_F00D;
      step();
      bus_ack = 1'b0;
      m_rdata = 32'h0BAD_F00D;
      chk("second_ack", {31'd0, data_mem_ack}, 32'd1);
      chk("second_rdata", read_data_M, m_rdata);
      advance_M = 1'b1;
      step();
      advance_M = 1'b0;
      mem_rd_M  = 1'b0;

      // Reset asserted mid-BUSY
      mem_rd_M = 1'b1;
      addr_M   = 32'h0000_0700;
      step();
      chk("pre_reset_req", {31'd0, bus_req}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_req", {31'd0, bus_req}, 32'd0);
      chk("midrst_rdata", read_data_M, 32'd0);
      chk("midrst_addr", {16'd0, bus_addr}, 32'd0);
      mem_rd_M = 1'b0;
      m_rdata  = 32'h0;
      step();
      reset = 1'b1;
      step();
      access(1'b0, 32'h0000_0808, 32'h0, 4'h0, 2, 32'hA5A5_5A5A, 1);

      // Randomized accesses against the model
      for (int i = 0; i < 40; i++) begin
         access(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(1, 15)),
                $urandom_range(0, 4), $urandom, $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
